ps2_keyboard_rx: RTL

// - Host-side PS/2 keyboard receiver: samples the keyboard clock/data lines, deframes 11-bit frames and decodes
//   set-2 scancode prefixes (E0, F0, E1) into one event per key.
// - Produces the kstb/make/code event stream consumed by the keyboard matrix block; sits at top level between pins and main.
// - Receive only; ps2Ck/ps2D are never driven.

---
 rtl/ps2_keyboard_rx_pkg.sv | 11 +
 rtl/ps2_frame_rx.sv | 105 ++++++++++
 rtl/ps2_keyboard_rx.sv | 96 +++++++++
 3 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types for the PS/2 keyboard receiver slice.
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer: synchroniser, clock glitch filter,
// frame FSM and inter-edge timeout. Strobes are combinational, one clock wide.
module ps2_frame_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 7000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_i,
    input  logic       ps2_ck_i,
    input  logic       ps2_d_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       perr_o
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          ck_meta_q, ck_sync_q, d_meta_q, d_sync_q;
    logic          ck_filt_q;
    logic [FW-1:0] flt_cnt_q;
    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;

    logic fall, timeout, stop_edge, frame_ok;

    // The FILTER-th disagreeing high->low sample is the falling edge itself.
    assign fall      = ce_i && ck_filt_q && !ck_sync_q && (flt_cnt_q == FW'(FILTER - 1));
    assign timeout   = ce_i && !fall && (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT - 1));
    assign stop_edge = fall && (state_q == ST_STOP);
    assign frame_ok  = d_sync_q && (^{shift_q, par_q});

    assign byte_o  = shift_q;
    assign valid_o = stop_edge && frame_ok;
    assign perr_o  = stop_edge && !frame_ok;
    assign err_o   = perr_o || timeout || (fall && (state_q == ST_IDLE) && d_sync_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            ck_meta_q <= 1'b1;
            ck_sync_q <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
            ck_filt_q <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            ck_meta_q <= ps2_ck_i;
            ck_sync_q <= ck_meta_q;
            d_meta_q  <= ps2_d_i;
            d_sync_q  <= d_meta_q;

            if (ce_i) begin
                if (ck_sync_q != ck_filt_q) begin
                    if (flt_cnt_q == FW'(FILTER - 1)) begin
                        ck_filt_q <= ck_sync_q;
                        flt_cnt_q <= '0;
                    end else begin
                        flt_cnt_q <= flt_cnt_q + 1'b1;
                    end
                end else begin
                    flt_cnt_q <= '0;
                end
            end

            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!d_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {d_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= d_sync_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: state_q <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state_q  <= ST_IDLE;
                to_cnt_q <= '0;
            end else if (ce_i && (state_q != ST_IDLE)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Host-side PS/2 keyboard receiver: deframes bytes and folds set-2 prefixes (E0, F0, E1)
// into one make/break event per key.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 7000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       kstb,
    output logic       make,
    output logic       ext,
    output logic [7:0] code,
    output logic       err
);
    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [7:0] f_byte;
    logic       f_valid, f_err, f_perr;

    ps2_frame_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_frame (
        .clock   (clock),
        .reset   (reset),
        .ce_i    (ce),
        .ps2_ck_i(ps2Ck),
        .ps2_d_i (ps2D),
        .byte_o  (f_byte),
        .valid_o (f_valid),
        .err_o   (f_err),
        .perr_o  (f_perr)
    );

    logic       kstb_q, err_q, make_q, ext_q;
    logic [7:0] code_q;
    logic       brk_q, extf_q;
    logic [2:0] skip_q;

    assign kstb = kstb_q;
    assign err  = err_q;
    assign make = make_q;
    assign ext  = ext_q;
    assign code = code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            kstb_q <= 1'b0;
            err_q  <= 1'b0;
            make_q <= 1'b0;
            ext_q  <= 1'b0;
            code_q <= 8'h00;
            brk_q  <= 1'b0;
            extf_q <= 1'b0;
            skip_q <= '0;
        end else begin
            kstb_q <= 1'b0;
            err_q  <= f_err;
            // A corrupt frame may have been a prefix; never let it tag the next key.
            if (f_perr) begin
                brk_q  <= 1'b0;
                extf_q <= 1'b0;
            end
            if (f_valid) begin
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 1'b1;
                end else if (f_byte == B_E1) begin
                    skip_q <= 3'd7;
                end else if (f_byte == B_E0) begin
                    extf_q <= 1'b1;
                end else if (f_byte == B_F0) begin
                    brk_q <= 1'b1;
                end else if (!is_status(f_byte)) begin
                    kstb_q <= 1'b1;
                    code_q <= f_byte;
                    make_q <= ~brk_q;
                    ext_q  <= extf_q;
                    brk_q  <= 1'b0;
                    extf_q <= 1'b0;
                end
            end
        end
    end

endmodule
